// File: rtl/hirose_present_chain_pkg.sv
// Shared types and PRESENT-80 round primitives for the Hirose chaining engine.
// Pure constants and functions; no state.
package hirose_pkg;

  localparam int MSG_W = 16;
  localparam int KEY_W = 80;

  localparam logic [63:0] C_DEFAULT    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] IV_L_DEFAULT = 64'h0;
  localparam logic [63:0] IV_R_DEFAULT = 64'h0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    UPDATE,
    DONE
  } state_t;

  // Nibble x of each table holds S(x) / S^-1(x).
  localparam logic [63:0] SBOX_TBL     = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] SBOX_INV_TBL = 64'hA970_364B_D21C_8FE5;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    return SBOX_INV_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[6'(i * 4) +: 4] = sbox(x[6'(i * 4) +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] s_layer_inv(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[6'(i * 4) +: 4] = sbox_inv(x[6'(i * 4) +: 4]);
    return r;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 stays put.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) r[6'((i * 16) % 63)] = x[6'(i)];
    r[63] = x[63];
    return r;
  endfunction

  function automatic logic [63:0] p_layer_inv(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) r[6'(i)] = x[6'((i * 16) % 63)];
    r[63] = x[63];
    return r;
  endfunction

  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox(t[79:76]);
    t[19:15] = t[19:15] ^ rc;
    return t;
  endfunction

  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = k;
    t[19:15] = t[19:15] ^ rc;
    t[79:76] = sbox_inv(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

endpackage

// File: rtl/hirose_present_chain_present.sv
// Iterative PRESENT-80 core, one round per cycle; encryption done 32 cycles after reset release.
// Decryption first rolls the key schedule forward 31 cycles (end_key_generation), then inverts.
module present
  import hirose_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_dec,
  input  logic [79:0] key,
  input  logic [63:0] block_i,
  output logic [63:0] block_o,
  output logic        end_enc,
  output logic        end_key_generation
);

  logic [63:0] st;
  logic [79:0] rk;
  logic [4:0]  rnd;
  logic        whiten;
  logic [79:0] rk_next;
  logic [79:0] rk_prev;

  assign rk_next = key_fwd(rk, rnd);
  assign rk_prev = key_inv(rk, rnd);
  assign block_o = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st                 <= block_i;
      rk                 <= key;
      rnd                <= 5'd1;
      whiten             <= 1'b1;
      end_enc            <= 1'b0;
      end_key_generation <= !enc_dec;
    end else if (!end_key_generation) begin
      // Roll the schedule up to K32 and park the counter on the last round.
      rk <= rk_next;
      if (rnd == 5'd31) end_key_generation <= 1'b1;
      else              rnd <= rnd + 5'd1;
    end else if (!end_enc) begin
      if (!enc_dec) begin
        if (rnd != 5'd0) begin
          st  <= p_layer(s_layer(st ^ rk[79:16]));
          rk  <= rk_next;
          rnd <= rnd + 5'd1;
        end else begin
          st      <= st ^ rk[79:16];
          end_enc <= 1'b1;
        end
      end else if (whiten) begin
        st     <= st ^ rk[79:16];
        whiten <= 1'b0;
      end else begin
        st  <= s_layer_inv(p_layer_inv(st)) ^ rk_prev[79:16];
        rk  <= rk_prev;
        rnd <= rnd - 5'd1;
        if (rnd == 5'd1) end_enc <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hirose_present_chain.sv
// Hirose double-block-length hash over 16-bit blocks, chaining (G,H) across blocks; core latency + 3 cycles per block.
// msg_ready only in IDLE; digest held on hash_valid until hash_ready.
module hirose_present_chain
  import hirose_pkg::*;
#(
  parameter logic [63:0] C        = C_DEFAULT,
  parameter logic [63:0] IV_L     = IV_L_DEFAULT,
  parameter logic [63:0] IV_R     = IV_R_DEFAULT,
  parameter int          DIGEST_W = 128,
  parameter int          CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  logic [MSG_W-1:0]    msg_data,
  input  logic                msg_last,
  output logic                hash_valid,
  input  logic                hash_ready,
  output logic [DIGEST_W-1:0] hash_o,
  output logic [CNT_W-1:0]    blocks,
  output logic                overflow,
  output logic                busy
);

  state_t           state;
  logic [63:0]      g;
  logic [63:0]      h;
  logic [KEY_W-1:0] key;
  logic             last;
  logic             core_rst;
  logic [63:0]      e_l;
  logic [63:0]      e_r;
  logic             enc_done_l, enc_done_r, key_done_l, key_done_r;
  logic             cores_done;
  logic [63:0]      g_nxt;
  logic [63:0]      h_nxt;
  logic [127:0]     gh_nxt;
  logic [CNT_W-1:0] blocks_inc;

  // LOAD re-arms both cores so every block starts from a clean schedule.
  assign core_rst   = !rst || (state == LOAD);
  assign cores_done = enc_done_l && enc_done_r && key_done_l && key_done_r;
  assign g_nxt      = e_l ^ g;
  assign h_nxt      = e_r ^ g ^ C;
  assign gh_nxt     = {g_nxt, h_nxt};
  assign blocks_inc = blocks + CNT_W'(1);

  present u_core_l (
    .clk                (clk),
    .rst                (core_rst),
    .enc_dec            (1'b0),
    .key                (key),
    .block_i            (g),
    .block_o            (e_l),
    .end_enc            (enc_done_l),
    .end_key_generation (key_done_l)
  );

  present u_core_r (
    .clk                (clk),
    .rst                (core_rst),
    .enc_dec            (1'b0),
    .key                (key),
    .block_i            (g ^ C),
    .block_o            (e_r),
    .end_enc            (enc_done_r),
    .end_key_generation (key_done_r)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      g          <= IV_L;
      h          <= IV_R;
      key        <= '0;
      last       <= 1'b0;
      blocks     <= '0;
      overflow   <= 1'b0;
      msg_ready  <= 1'b0;
      hash_valid <= 1'b0;
      hash_o     <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          msg_ready <= 1'b1;
          if (msg_ready && msg_valid) begin
            key       <= {h, msg_data};
            last      <= msg_last;
            msg_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: state <= RUN;
        RUN: if (cores_done) state <= UPDATE;
        UPDATE: begin
          g      <= g_nxt;
          h      <= h_nxt;
          blocks <= blocks_inc;
          if (blocks_inc == '0) overflow <= 1'b1;
          if (last) begin
            hash_valid <= 1'b1;
            hash_o     <= gh_nxt[127 -: DIGEST_W];
            state      <= DONE;
          end else begin
            msg_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        DONE: begin
          if (hash_ready) begin
            g          <= IV_L;
            h          <= IV_R;
            blocks     <= '0;
            overflow   <= 1'b0;
            hash_valid <= 1'b0;
            hash_o     <= '0;
            msg_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
